lc3_console_bridge: RTL

//   Parametrised, buffered successor to the console INPUT/OUTPUT handshake pair. It sits

---
 rtl/lc3_io_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 66 ++++++
 rtl/lc3_console_bridge.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/lc3_io_pkg.sv
// Shared definitions for the LC-3 console bridge.
// - Bit positions used in the KBSR and DSR status words.
// - Encoding of the TX handshake state machine.
// - status_word(): assembles a {ready, ie, err, 13'b0} status register image.
package lc3_io_pkg;

  localparam int READY_BIT = 15;
  localparam int IE_BIT    = 14;
  localparam int ERR_BIT   = 13;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_WAIT = 1'b1
  } tx_state_t;

  function automatic logic [15:0] status_word(input logic ready, input logic ie, input logic err);
    logic [15:0] w;
    w            = '0;
    w[READY_BIT] = ready;
    w[IE_BIT]    = ie;
    w[ERR_BIT]   = err;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head output.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset (pointers/count only)
//   push, din   write request and data; accepted when not full, or when full
//               and a pop is accepted in the same cycle
//   pop         read request; ignored when empty
//   dout        current head entry, 0 when empty
//   full, empty occupancy flags taken from an (AW+1)-bit count
module sync_fifo #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a write when a slot frees up in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr_reg];

  // Storage carries no reset; only pointers and count define validity.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (do_push && (wr_ptr_reg == AW'(gi))) begin
          mem[gi] <= din;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/lc3_console_bridge.sv
// Buffered bridge between LC-3 console registers (KBSR/KBDR/DSR/DDR) and a
// uart_rx/uart_tx pair, with RX/TX FIFOs, interrupt enables and sticky flags.
// Ports:
//   i_Clk, reset_          clock, asynchronous active-low reset
//   kb_rd                  CPU reads KBDR (pops RX FIFO)
//   kbsr_wr, dsr_wr        CPU control writes (IE bit, W1C error bit)
//   ddr_wr, wdata          CPU writes DDR (pushes TX FIFO) / write data
//   kbsr, kbdr, dsr        register read images
//   kb_irq, disp_irq       level interrupt requests
//   rx_dv, rx_byte         byte from uart_rx
//   tx_send, tx_byte       start pulse and byte to uart_tx
//   tx_done                uart_tx completion pulse
module lc3_console_bridge
  import lc3_io_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int RX_AW  = 4,
  parameter int TX_AW  = 4
) (
  input  logic              i_Clk,
  input  logic              reset_,
  input  logic              kb_rd,
  input  logic              kbsr_wr,
  input  logic              dsr_wr,
  input  logic              ddr_wr,
  input  logic [15:0]       wdata,
  output logic [15:0]       kbsr,
  output logic [15:0]       kbdr,
  output logic [15:0]       dsr,
  output logic              kb_irq,
  output logic              disp_irq,
  input  logic              rx_dv,
  input  logic [DATA_W-1:0] rx_byte,
  output logic              tx_send,
  output logic [DATA_W-1:0] tx_byte,
  input  logic              tx_done
);

  logic [DATA_W-1:0] rx_head;
  logic              rx_full;
  logic              rx_empty;
  logic [DATA_W-1:0] tx_head;
  logic              tx_full;
  logic              tx_empty;
  logic              tx_pop;

  logic              kb_ie_reg,   kb_ie_next;
  logic              disp_ie_reg, disp_ie_next;
  logic              rx_ovr_reg,  rx_ovr_next;
  logic              tx_drop_reg, tx_drop_next;
  tx_state_t         state_reg,   state_next;
  logic              tx_send_reg, tx_send_next;
  logic [DATA_W-1:0] tx_byte_reg, tx_byte_next;

  // Not every wdata bit is meaningful for every register.
  logic wdata_unused;
  assign wdata_unused = ^wdata;

  sync_fifo #(.DW(DATA_W), .AW(RX_AW)) u_rx_fifo (
    .clk   (i_Clk),
    .rst_n (reset_),
    .push  (rx_dv),
    .pop   (kb_rd),
    .din   (rx_byte),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  sync_fifo #(.DW(DATA_W), .AW(TX_AW)) u_tx_fifo (
    .clk   (i_Clk),
    .rst_n (reset_),
    .push  (ddr_wr),
    .pop   (tx_pop),
    .din   (wdata[DATA_W-1:0]),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  // Control and sticky flags. A full FIFO is never empty, so a read/FSM pop
  // in the same cycle always frees a slot; a set beats a W1C clear.
  always_comb begin
    kb_ie_next   = kbsr_wr ? wdata[IE_BIT] : kb_ie_reg;
    disp_ie_next = dsr_wr  ? wdata[IE_BIT] : disp_ie_reg;
    rx_ovr_next  = (rx_dv && rx_full && !kb_rd) ||
                   (rx_ovr_reg && !(kbsr_wr && wdata[ERR_BIT]));
    tx_drop_next = (ddr_wr && tx_full && !tx_pop) ||
                   (tx_drop_reg && !(dsr_wr && wdata[ERR_BIT]));
  end

  // TX handshake FSM: IDLE launches the head byte, WAIT holds it until tx_done.
  assign tx_pop = (state_reg == TX_IDLE) && !tx_empty;

  always_comb begin
    state_next   = state_reg;
    tx_send_next = 1'b0;
    tx_byte_next = tx_byte_reg;
    case (state_reg)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_byte_next = tx_head;
          tx_send_next = 1'b1;
          state_next   = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (tx_done) state_next = TX_IDLE;
      end
      default: state_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge reset_) begin
    if (!reset_) begin
      kb_ie_reg   <= 1'b0;
      disp_ie_reg <= 1'b0;
      rx_ovr_reg  <= 1'b0;
      tx_drop_reg <= 1'b0;
      state_reg   <= TX_IDLE;
      tx_send_reg <= 1'b0;
      tx_byte_reg <= '0;
    end else begin
      kb_ie_reg   <= kb_ie_next;
      disp_ie_reg <= disp_ie_next;
      rx_ovr_reg  <= rx_ovr_next;
      tx_drop_reg <= tx_drop_next;
      state_reg   <= state_next;
      tx_send_reg <= tx_send_next;
      tx_byte_reg <= tx_byte_next;
    end
  end

  always_comb begin
    kbdr               = '0;
    kbdr[DATA_W-1:0]   = rx_head;
  end

  assign kbsr     = status_word(!rx_empty, kb_ie_reg, rx_ovr_reg);
  assign dsr      = status_word(!tx_full, disp_ie_reg, tx_drop_reg);
  assign kb_irq   = kbsr[READY_BIT] & kbsr[IE_BIT];
  assign disp_irq = dsr[READY_BIT] & dsr[IE_BIT];
  assign tx_send  = tx_send_reg;
  assign tx_byte  = tx_byte_reg;

endmodule
